// File: rtl/audio_sfx_pkg.sv
// Shared types and the canned effect table for the sound-effect sequencer.
// Each entry holds the two notes' half-periods and lengths, counted in codec samples.
package audio_sfx_pkg;

  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    NOTE0,
    NOTE1
  } sfx_state_e;

  typedef struct packed {
    logic [7:0]  half0;
    logic [15:0] len0;
    logic [7:0]  half1;
    logic [15:0] len1;
  } sfx_entry_t;

  // Index 0 is the rightmost element: hit, miss, start, game-over.
  localparam sfx_entry_t [3:0] SFX_TABLE = {
    sfx_entry_t'{half0: 8'd96, len0: 16'd9600, half1: 8'd120, len1: 16'd19200},
    sfx_entry_t'{half0: 8'd36, len0: 16'd4800, half1: 8'd18,  len1: 16'd4800},
    sfx_entry_t'{half0: 8'd60, len0: 16'd4800, half1: 8'd80,  len1: 16'd4800},
    sfx_entry_t'{half0: 8'd24, len0: 16'd2400, half1: 8'd12,  len1: 16'd2400}
  };

endpackage

// File: rtl/audio_sfx_player_if.sv
// Sample push bus between the effect player (master) and Audio_Controller (slave).
interface audio_sfx_player_if;
  import audio_sfx_pkg::*;

  logic                       audio_out_allowed;
  logic signed [SAMPLE_W-1:0] left_channel_audio_out;
  logic signed [SAMPLE_W-1:0] right_channel_audio_out;
  logic                       write_audio_out;

  modport master (
    input  audio_out_allowed,
    output left_channel_audio_out,
    output right_channel_audio_out,
    output write_audio_out
  );

  modport slave (
    output audio_out_allowed,
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    input  write_audio_out
  );

endinterface

// File: rtl/audio_sfx_tone.sv
// Square-wave oscillator with a stepped envelope that halves amplitude every ENV_STEP samples.
// The registered sample is computed from next-state values so it changes right after each consumed write.
module audio_sfx_tone
  import audio_sfx_pkg::*;
#(
  parameter logic [31:0] AMPLITUDE = 32'd10000000,
  parameter int          ENV_STEP  = 1200,
  parameter int          ENV_MAX   = 7
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       restart,
  input  logic                       advance,
  input  logic                       mute,
  input  logic [7:0]                 half,
  output logic signed [SAMPLE_W-1:0] sample
);

  localparam logic [15:0] ENV_LAST  = 16'(ENV_STEP - 1);
  localparam logic [4:0]  SHIFT_MAX = 5'(ENV_MAX);

  logic                       phase_q, phase_d;
  logic [7:0]                 half_cnt_q, half_cnt_d;
  logic [15:0]                env_cnt_q, env_cnt_d;
  logic [4:0]                 env_shift_q, env_shift_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic signed [SAMPLE_W-1:0] amp;

  always_comb begin
    phase_d     = phase_q;
    half_cnt_d  = half_cnt_q;
    env_cnt_d   = env_cnt_q;
    env_shift_d = env_shift_q;
    if (restart) begin
      phase_d     = 1'b1;
      half_cnt_d  = '0;
      env_cnt_d   = '0;
      env_shift_d = '0;
    end else if (advance) begin
      if (half_cnt_q == half - 8'd1) begin
        phase_d    = ~phase_q;
        half_cnt_d = '0;
      end else begin
        half_cnt_d = half_cnt_q + 8'd1;
      end
      if (env_cnt_q == ENV_LAST) begin
        env_cnt_d = '0;
        if (env_shift_q < SHIFT_MAX) env_shift_d = env_shift_q + 5'd1;
      end else begin
        env_cnt_d = env_cnt_q + 16'd1;
      end
    end
    amp      = $signed(AMPLITUDE) >>> env_shift_d;
    sample_d = mute ? '0 : (phase_d ? amp : -amp);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase_q     <= 1'b0;
      half_cnt_q  <= '0;
      env_cnt_q   <= '0;
      env_shift_q <= '0;
      sample_q    <= '0;
    end else begin
      phase_q     <= phase_d;
      half_cnt_q  <= half_cnt_d;
      env_cnt_q   <= env_cnt_d;
      env_shift_q <= env_shift_d;
      sample_q    <= sample_d;
    end
  end

  assign sample = sample_q;

endmodule

// File: rtl/audio_sfx_player.sv
// Two-note effect sequencer feeding Audio_Controller one stereo sample per write handshake.
// The FSM owns note length counting and table lookup; the tone sub-module owns pitch and envelope.
module audio_sfx_player
  import audio_sfx_pkg::*;
#(
  parameter logic [31:0] AMPLITUDE = 32'd10000000,
  parameter int          ENV_STEP  = 1200,
  parameter int          ENV_MAX   = 7
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               trigger,
  input  logic [1:0]         sfx_id,
  output logic               busy,
  audio_sfx_player_if.master aud
);

  sfx_state_e                 state_q, state_d;
  sfx_entry_t                 entry_q, entry_d;
  logic [15:0]                len_cnt_q, len_cnt_d;
  logic [7:0]                 cur_half;
  logic [15:0]                cur_len;
  logic                       write;
  logic                       restart;
  logic                       advance;
  logic signed [SAMPLE_W-1:0] sample;

  assign busy     = (state_q != IDLE);
  assign write    = busy & aud.audio_out_allowed;
  assign cur_half = (state_q == NOTE1) ? entry_q.half1 : entry_q.half0;
  assign cur_len  = (state_q == NOTE1) ? entry_q.len1  : entry_q.len0;

  // A trigger always wins, even over the final write of the running effect.
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    len_cnt_d = len_cnt_q;
    restart   = 1'b0;
    advance   = 1'b0;
    if (trigger) begin
      state_d   = NOTE0;
      entry_d   = SFX_TABLE[sfx_id];
      len_cnt_d = '0;
      restart   = 1'b1;
    end else if (write) begin
      advance = 1'b1;
      if (len_cnt_q == cur_len - 16'd1) begin
        len_cnt_d = '0;
        restart   = 1'b1;
        state_d   = (state_q == NOTE0) ? NOTE1 : IDLE;
      end else begin
        len_cnt_d = len_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= IDLE;
      entry_q   <= '0;
      len_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      len_cnt_q <= len_cnt_d;
    end
  end

  audio_sfx_tone #(
    .AMPLITUDE (AMPLITUDE),
    .ENV_STEP  (ENV_STEP),
    .ENV_MAX   (ENV_MAX)
  ) u_tone (
    .clk     (CLOCK_50),
    .resetn  (resetn),
    .restart (restart),
    .advance (advance),
    .mute    (state_d == IDLE),
    .half    (cur_half),
    .sample  (sample)
  );

  assign aud.left_channel_audio_out  = sample;
  assign aud.right_channel_audio_out = sample;
  assign aud.write_audio_out         = write;

endmodule

// File: tb/tb_audio_sfx_player.sv
// Directed bench for audio_sfx_player: captures every consumed sample and compares
// against hand-picked values and a small effect-table model.
module tb_audio_sfx_player;

  localparam logic signed [31:0] AMP = 32'sd10000000;
  localparam int CAP = 20000;

  logic       clk;
  logic       resetn;
  logic       trigger;
  logic [1:0] sfx_id;
  logic       busy;

  audio_sfx_player_if aif();

  audio_sfx_player dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .trigger  (trigger),
    .sfx_id   (sfx_id),
    .busy     (busy),
    .aud      (aif)
  );

  int checks = 0;
  int errors = 0;
  int right_diff;
  logic signed [31:0] samples [0:CAP-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [31:0] model_sample(input int id, input int k);
    int h0, l0, h1, h, kk, sh;
    logic signed [31:0] amp;
    case (id)
      0:       begin h0 = 24; l0 = 2400; h1 = 12;  end
      1:       begin h0 = 60; l0 = 4800; h1 = 80;  end
      2:       begin h0 = 36; l0 = 4800; h1 = 18;  end
      default: begin h0 = 96; l0 = 9600; h1 = 120; end
    endcase
    if (k < l0) begin h = h0; kk = k; end
    else begin h = h1; kk = k - l0; end
    sh = kk / 1200;
    if (sh > 7) sh = 7;
    amp = AMP >>> sh;
    return (((kk / h) % 2) == 0) ? amp : -amp;
  endfunction

  task automatic start_effect(input logic [1:0] id);
    @(negedge clk);
    sfx_id  = id;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  // Starts and ends on a falling edge; stops early when stop_after writes have been seen.
  task automatic capture(input bit stall, input int stop_after, input int max_cycles,
                         output int nwrites, output int ncycles, output bit timeout);
    nwrites    = 0;
    ncycles    = 0;
    timeout    = 1'b0;
    right_diff = 0;
    while (1) begin
      if (stop_after > 0 && nwrites == stop_after) break;
      aif.audio_out_allowed = stall ? ((ncycles % 4) == 3) : 1'b1;
      #1;
      if (!busy) break;
      if (aif.write_audio_out) begin
        if (nwrites < CAP) samples[nwrites] = aif.left_channel_audio_out;
        if (aif.right_channel_audio_out !== aif.left_channel_audio_out) right_diff++;
        nwrites++;
      end
      ncycles++;
      if (ncycles >= max_cycles) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
    end
    aif.audio_out_allowed = 1'b1;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    trigger = 1'b0;
    sfx_id  = 2'd0;
    aif.audio_out_allowed = 1'b1;
    repeat (3) @(negedge clk);
    trigger = 1'b1;
    sfx_id  = 2'd3;
    @(negedge clk);
    trigger = 1'b0;
    resetn  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || aif.write_audio_out !== 1'b0 ||
          aif.left_channel_audio_out !== 32'sd0 || aif.right_channel_audio_out !== 32'sd0) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: busy=%b write=%b left=%0d right=%0d required all 0",
                 i, busy, aif.write_audio_out, aif.left_channel_audio_out, aif.right_channel_audio_out);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hit();
    int nw, nc, bad;
    bit to;
    logic signed [31:0] exp_v [6];
    int idx [6];
    start_effect(2'd0);
    capture(1'b0, 0, 20000, nw, nc, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL hit_timeout: cycles=%0d", nc); end
    checks++;
    if (nw !== 4800) begin errors++; $display("[TB] FAIL hit_count: got %0d required 4800", nw); end
    idx = '{0, 23, 24, 1199, 1200, 2400};
    exp_v = '{AMP, AMP, -AMP, -AMP, 32'sd5000000, AMP};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (samples[idx[i]] !== exp_v[i]) begin
        errors++;
        $display("[TB] FAIL hit_sample[%0d]: got %0d required %0d", idx[i], samples[idx[i]], exp_v[i]);
      end
    end
    checks++;
    if (samples[2412] !== -AMP) begin
      errors++;
      $display("[TB] FAIL hit_note1_half: sample 2412 got %0d required %0d", samples[2412], -AMP);
    end
    bad = -1;
    for (int k = 0; k < 4800; k++)
      if (bad < 0 && samples[k] !== model_sample(0, k)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL hit_model: sample %0d got %0d required %0d", bad, samples[bad], model_sample(0, bad));
    end
    checks++;
    if (right_diff !== 0) begin errors++; $display("[TB] FAIL hit_right_eq_left: %0d differing writes, required 0", right_diff); end
    checks++;
    if (busy !== 1'b0 || aif.left_channel_audio_out !== 32'sd0 || aif.write_audio_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hit_end_idle: busy=%b left=%0d write=%b required 0", busy, aif.left_channel_audio_out, aif.write_audio_out);
    end
  endtask

  task automatic test_stall();
    int nw, nc, bad;
    bit to;
    start_effect(2'd1);
    capture(1'b1, 0, 50000, nw, nc, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL stall_timeout: cycles=%0d", nc); end
    checks++;
    if (nw !== 9600) begin errors++; $display("[TB] FAIL stall_count: got %0d required 9600", nw); end
    checks++;
    if (nc !== 38400) begin errors++; $display("[TB] FAIL stall_cycles: got %0d required 38400", nc); end
    bad = -1;
    for (int k = 0; k < 9600; k++)
      if (bad < 0 && samples[k] !== model_sample(1, k)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL stall_model: sample %0d got %0d required %0d", bad, samples[bad], model_sample(1, bad));
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stall_end_busy: got %b required 0", busy); end
  endtask

  task automatic test_saturate();
    int nw, nc, bad, badmag;
    bit to;
    start_effect(2'd3);
    capture(1'b0, 9700, 20000, nw, nc, to);
    checks++;
    if (nw !== 9700) begin errors++; $display("[TB] FAIL sat_count: got %0d required 9700", nw); end
    checks++;
    if (samples[8399] !== -32'sd156250) begin errors++; $display("[TB] FAIL sat_s8399: got %0d required -156250", samples[8399]); end
    checks++;
    if (samples[8400] !== -32'sd78125) begin errors++; $display("[TB] FAIL sat_s8400: got %0d required -78125", samples[8400]); end
    checks++;
    if (samples[9600] !== AMP) begin errors++; $display("[TB] FAIL sat_note1_start: got %0d required %0d", samples[9600], AMP); end
    badmag = -1;
    for (int k = 8400; k < 9600; k++)
      if (badmag < 0 && samples[k] !== 32'sd78125 && samples[k] !== -32'sd78125) badmag = k;
    checks++;
    if (badmag >= 0) begin errors++; $display("[TB] FAIL sat_magnitude: sample %0d got %0d required +-78125", badmag, samples[badmag]); end
    bad = -1;
    for (int k = 0; k < 9700; k++)
      if (bad < 0 && samples[k] !== model_sample(3, k)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL sat_model: sample %0d got %0d required %0d", bad, samples[bad], model_sample(3, bad));
    end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_retrigger();
    int nw, nc, bad;
    bit to;
    start_effect(2'd3);
    capture(1'b0, 100, 1000, nw, nc, to);
    checks++;
    if (nw !== 100) begin errors++; $display("[TB] FAIL retrig_pre_count: got %0d required 100", nw); end
    trigger = 1'b1;
    sfx_id  = 2'd0;
    #1;
    checks++;
    if (aif.write_audio_out !== 1'b1 || aif.left_channel_audio_out !== -AMP) begin
      errors++;
      $display("[TB] FAIL retrig_write100: write=%b left=%0d required 1 and %0d", aif.write_audio_out, aif.left_channel_audio_out, -AMP);
    end
    @(negedge clk);
    trigger = 1'b0;
    capture(1'b0, 0, 20000, nw, nc, to);
    checks++;
    if (nw !== 4800 || to) begin errors++; $display("[TB] FAIL retrig_count: got %0d timeout=%b required 4800", nw, to); end
    checks++;
    if (samples[0] !== AMP || samples[23] !== AMP || samples[24] !== -AMP) begin
      errors++;
      $display("[TB] FAIL retrig_first_note: s0=%0d s23=%0d s24=%0d required %0d %0d %0d",
               samples[0], samples[23], samples[24], AMP, AMP, -AMP);
    end
    bad = -1;
    for (int k = 0; k < 4800; k++)
      if (bad < 0 && samples[k] !== model_sample(0, k)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL retrig_model: sample %0d got %0d required %0d", bad, samples[bad], model_sample(0, bad));
    end
  endtask

  task automatic test_reset_mid();
    int nw, nc;
    bit to;
    start_effect(2'd2);
    capture(1'b0, 500, 2000, nw, nc, to);
    checks++;
    if (nw !== 500) begin errors++; $display("[TB] FAIL rstmid_pre_count: got %0d required 500", nw); end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || aif.write_audio_out !== 1'b0 || aif.left_channel_audio_out !== 32'sd0) begin
        errors++;
        $display("[TB] FAIL rstmid_silent cycle %0d: busy=%b write=%b left=%0d required 0",
                 i, busy, aif.write_audio_out, aif.left_channel_audio_out);
      end
      @(negedge clk);
    end
    start_effect(2'd2);
    capture(1'b0, 40, 200, nw, nc, to);
    checks++;
    if (nw !== 40 || samples[0] !== AMP || samples[35] !== AMP || samples[36] !== -AMP) begin
      errors++;
      $display("[TB] FAIL rstmid_restart: n=%0d s0=%0d s35=%0d s36=%0d required 40 %0d %0d %0d",
               nw, samples[0], samples[35], samples[36], AMP, AMP, -AMP);
    end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_stall();
    test_saturate();
    test_retrigger();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_sfx_player.md
# audio_sfx_player

Sound-effect sequencer that sits directly upstream of `Audio_Controller`'s DAC path. On a one-cycle trigger it plays one of four canned two-note square-wave effects (hit, miss, start, game-over) with a stepped-decay envelope. It delivers one stereo sample per `write_audio_out` handshake, so pitch and duration are counted in codec samples (48 kHz), independent of `CLOCK_50`.

## Interface

Parameters:
- `AMPLITUDE`, default 32'd10000000: peak sample magnitude at envelope step 0.
- `ENV_STEP`, default 1200: samples per envelope step (amplitude halves each step).
- `ENV_MAX`, default 7: maximum envelope shift.

Ports:
- `CLOCK_50`  in  1  system clock; the only clock.
- `resetn`  in  1  reset, synchronous and active-low.
- `trigger`  in  1  single-cycle request to start an effect.
- `sfx_id`  in  2  effect select, sampled with `trigger`: 0 hit, 1 miss, 2 start, 3 game-over.
- `audio_out_allowed`  in  1  from `Audio_Controller`; DAC FIFO has space.
- `left_channel_audio_out`  out  32  signed sample.
- `right_channel_audio_out`  out  32  signed sample, always equal to left.
- `write_audio_out`  out  1  push strobe to `Audio_Controller`.
- `busy`  out  1  high while an effect is playing.

## Operation

- States: IDLE, NOTE0, NOTE1.
  - IDLE → NOTE0 on `trigger`.
  - NOTE0 → NOTE1 after `len0` writes.
  - NOTE1 → IDLE after `len1` writes.
- Effect table (half-period in samples, length in samples):
  - id0: note 24 / 2400, then 12 / 2400.
  - id1: 60 / 4800, then 80 / 4800.
  - id2: 36 / 4800, then 18 / 4800.
  - id3: 96 / 9600, then 120 / 19200.
- Field widths: half-period 8 bits, length 16 bits.
- Note start (entering NOTE0 or NOTE1):
  - `phase` = 1; `half_cnt`, `len_cnt`, `env_cnt`, `env_shift` all = 0.
- Sample value:
  - `amp` = `AMPLITUDE >>> env_shift`.
  - Output = `phase ? amp : -amp`, two's complement, 32 bits, driven from registers.
  - In IDLE the output is 0.
- On each accepted write (`write_audio_out` high):
  - `half_cnt == half-1` → toggle `phase`, `half_cnt` = 0; else increment.
  - `env_cnt == ENV_STEP-1` → `env_cnt` = 0 and `env_shift` = min(`env_shift`+1, `ENV_MAX`); else increment.
  - `len_cnt == len-1` → next state; else increment.
- Retrigger: `trigger` in NOTE0/NOTE1 restarts at NOTE0 with the new `sfx_id`. This takes priority over any advance in the same cycle, including the final sample.
- `busy` = (state != IDLE).

## Timing

- Reset (`resetn` low at an edge):
  - state IDLE; outputs 0; `write_audio_out` 0; `busy` 0; all counters 0.
  - Reset mid-effect aborts silently with no further writes.
- `trigger` high at edge N in IDLE → `busy` high and the first sample (+`AMPLITUDE`) present after edge N.
- `write_audio_out` = `busy & audio_out_allowed`, combinational. The first write can occur in cycle N+1.
- The sample on the output bus in a write cycle is the one consumed. The next sample appears after that edge.
- `audio_out_allowed` low stalls all counters; the sample holds with no loss or duplication.
- Total writes per effect = `len0` + `len1` exactly. After the last write edge, the state is IDLE and outputs are 0.
- `trigger` with `resetn` low is ignored.

## Structure

- Package `audio_sfx_pkg`:
  - state enum.
  - effect-table record type {half0, len0, half1, len1}.
  - constant array of 4 entries.
  - sample width constant 32.
- Sub-module `audio_sfx_tone`:
  - square oscillator plus envelope (`phase`, `half_cnt`, `env_cnt`, `env_shift`, sample output).
  - `restart` and `advance` inputs.
  - The sequencer FSM owns `len_cnt` and table lookup.

## Test plan

- Reset, `audio_out_allowed` = 1 → outputs 0, `write_audio_out` 0, `busy` 0 for 100 cycles.
- `trigger`, id0, `allowed` tied high, `ENV_STEP` = 1200:
  - 4800 writes total.
  - Samples 0–23 = +10000000, samples 24–47 = −10000000.
  - Sample 1200 magnitude = 5000000.
  - Sample 2400 = +10000000 (new note, half-period 12).
  - `busy` low after write 4800.
- id1 with `allowed` toggling 1-of-4 cycles → write count 9600; sample sequence identical to the unstalled run.
- id3 → `env_shift` saturates at 7 (magnitude 78125) from sample 8400 through the end of note 0.
- Retrigger: id3 playing, `trigger` id0 on the same cycle as write 100 → next sample is +10000000 with note-0 half-period 24; total subsequent writes = 4800.
- `resetn` low for one edge at write 500 of id2 → IDLE, zero outputs, no writes until the next `trigger`.
